// File: rtl/hack_alu_pipe_if.sv
// -----------------------------------------------------------------------------
// hack_alu_pipe_if
// Operation/result handshake bundle for hack_alu_pipe.
//   in_valid / in_ready   : operation handshake (producer -> ALU)
//   x, y                  : WIDTH-bit operands
//   zx,nx,zy,ny,f,no      : Hack ALU control bits
//   mul                   : multiply request (used only in the ALU_MUL_EN build)
//   out_valid / out_ready : result handshake (ALU -> consumer)
//   out, zr, ng           : registered result and its flags
// Modports: master = operation producer / result consumer, slave = the ALU.
// -----------------------------------------------------------------------------
interface hack_alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             mul;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, mul, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/hack_alu_pipe.sv
// -----------------------------------------------------------------------------
// hack_alu_pipe
// Registered, WIDTH-parametrised Hack ALU with valid/ready handshakes on both
// sides. One non-multiply operation is accepted per cycle; the result and its
// zr/ng flags sit in an output register until the consumer drains them.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : hack_alu_pipe_if.slave (operation in, result out; see the interface)
//
// Build option: define ALU_MUL_EN to build the sequential shift-add multiplier
// (MUL state, bit counter, accumulator, operand shift registers). Without it,
// mul is ignored and every operation uses the single-cycle datapath.
//
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    hack_alu_pipe_if.slave bus
);

    // ---------------------------------------------------------------------
    // Hack datapath: all 64 control combinations fall out of these four
    // steps, there is no special-cased default.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] x_zeroed;
    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] y_zeroed;
    logic [WIDTH-1:0] y_op;
    logic [WIDTH-1:0] core_r;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        x_zeroed = bus.zx ? '0 : bus.x;
        x_op     = bus.nx ? ~x_zeroed : x_zeroed;
        y_zeroed = bus.zy ? '0 : bus.y;
        y_op     = bus.ny ? ~y_zeroed : y_zeroed;
        core_r   = bus.f ? (x_op + y_op) : (x_op & y_op);   // carry discarded
        alu_res  = bus.no ? ~core_r : core_r;
    end

    // ---------------------------------------------------------------------
    // Output register and handshake
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;
    logic             out_valid_q;
    logic             idle;
    logic             accept;
    logic             drain;

    // A held result blocks new work unless it is being drained on this edge.
    assign bus.in_ready  = !rst && idle && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] xreg_q;
    logic [WIDTH-1:0] yreg_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;

    assign idle  = (state_q == IDLE);
    // Partial product including the current multiplier bit; on the last step
    // this is the finished product, so it is loaded straight into out_q.
    assign acc_d = acc_q + (yreg_q[0] ? xreg_q : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
            xreg_q      <= '0;
            yreg_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.mul) begin
                            xreg_q      <= bus.x;
                            yreg_q      <= bus.y;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= MUL;
                        end else begin
                            out_q       <= alu_res;
                            zr_q        <= (alu_res == '0);
                            ng_q        <= alu_res[WIDTH-1];
                            out_valid_q <= 1'b1;
                        end
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    // Control bits are ignored here; low WIDTH bits of x*y
                    // are identical for signed and unsigned operands.
                    acc_q  <= acc_d;
                    xreg_q <= xreg_q << 1;
                    yreg_q <= yreg_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        out_q       <= acc_d;
                        zr_q        <= (acc_d == '0);
                        ng_q        <= acc_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    // Single-state machine: the block is always idle.
    assign idle = 1'b1;

    logic unused_mul;
    assign unused_mul = bus.mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                out_q       <= alu_res;
                zr_q        <= (alu_res == '0);
                ng_q        <= alu_res[WIDTH-1];
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hack_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_hack_alu_pipe
// Directed checks from the test plan followed by randomized traffic compared
// against a transaction-level reference model (result queue + busy counter).
// Works for both builds; ALU_MUL_EN selects the multiply expectations.
// -----------------------------------------------------------------------------
module tb_hack_alu_pipe;
    localparam int WIDTH = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hack_alu_pipe_if #(.WIDTH(WIDTH)) bus ();
    hack_alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                          input logic [5:0] c, input logic m);
        bus.x   = xv;
        bus.y   = yv;
        bus.zx  = c[5];
        bus.nx  = c[4];
        bus.zy  = c[3];
        bus.ny  = c[2];
        bus.f   = c[1];
        bus.no  = c[0];
        bus.mul = m;
    endtask

    // Reference: Hack rules on WIDTH-bit values, or a plain product when the
    // multiplier is built and requested.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] xv,
                                                 input logic [WIDTH-1:0] yv,
                                                 input logic [5:0] c, input logic m);
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [WIDTH-1:0]   r;
        logic [2*WIDTH-1:0] p;
        if (m && MUL_ON) begin
            p = {{WIDTH{1'b0}}, xv} * {{WIDTH{1'b0}}, yv};
            return p[WIDTH-1:0];
        end
        a = c[5] ? '0 : xv;
        if (c[4]) a = ~a;
        b = c[3] ? '0 : yv;
        if (c[2]) b = ~b;
        r = c[1] ? (a + b) : (a & b);
        return c[0] ? ~r : r;
    endfunction

    // Transaction-level model state
    logic [WIDTH-1:0] exp_q[$];
    bit               model_valid;
    int               busy;
    int               txn_no;

    task automatic rnd_cycle(input bit allow_new);
        logic [WIDTH-1:0] rx, ry, e;
        logic [5:0]       rc;
        logic             rm;
        bit               exp_ready, drain, accept;
        @(negedge clk);
        rx = WIDTH'($urandom);
        ry = WIDTH'($urandom);
        rc = 6'($urandom);
        rm = ($urandom_range(0, 9) < 2);
        set_op(rx, ry, rc, rm);
        bus.in_valid  = allow_new && ($urandom_range(0, 9) < 7);
        bus.out_ready = allow_new ? ($urandom_range(0, 9) < 7) : 1'b1;
        #1;
        exp_ready = (busy == 0) && (!model_valid || bus.out_ready);
        check("rnd_in_ready", bus.in_ready, exp_ready);
        check("rnd_out_valid", bus.out_valid, model_valid);
        drain  = model_valid && bus.out_ready;
        accept = bus.in_valid && exp_ready;
        if (drain) begin
            if (exp_q.size() == 0) begin
                check("rnd_queue_nonempty", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                txn_no++;
                $display("[TB] txn %0d out=0x%0h expect=0x%0h", txn_no, bus.out, e);
                check("rnd_out", bus.out, e);
                check("rnd_zr", bus.zr, (e == '0));
                check("rnd_ng", bus.ng, e[WIDTH-1]);
            end
        end
        if (busy > 0) begin
            busy--;
            if (busy == 0) model_valid = 1'b1;
        end else if (accept) begin
            exp_q.push_back(ref_alu(rx, ry, rc, rm));
            if (rm && MUL_ON) begin
                busy        = WIDTH;
                model_valid = 1'b0;
            end else begin
                model_valid = 1'b1;
            end
        end else if (drain) begin
            model_valid = 1'b0;
        end
    endtask

    logic [5:0]       b2b_ctrl [3];
    logic [WIDTH-1:0] b2b_exp  [3];

    initial begin
        b2b_ctrl = '{6'b101010, 6'b111111, 6'b111010};
        b2b_exp  = '{16'h0000, 16'h0001, 16'hFFFF};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_op('0, '0, 6'b0, 1'b0);

        // Reset
        repeat (3) @(negedge clk);
        check("rst_out", bus.out, 0);
        check("rst_zr", bus.zr, 1);
        check("rst_ng", bus.ng, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", bus.in_ready, 1);

        // Add 5 + 3
        bus.out_ready = 1'b1;
        set_op(16'd5, 16'd3, 6'b000010, 1'b0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("[TB] add 5+3 -> 0x%0h", bus.out);
        check("add_out", bus.out, 8);
        check("add_zr", bus.zr, 0);
        check("add_ng", bus.ng, 0);
        check("add_out_valid", bus.out_valid, 1);
        @(negedge clk);
        check("add_drained", bus.out_valid, 0);

        // Subtract 3 - 5 under backpressure
        bus.out_ready = 1'b0;
        set_op(16'd3, 16'd5, 6'b010011, 1'b0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("[TB] sub 3-5 -> 0x%0h", bus.out);
        check("sub_out", bus.out, 16'hFFFE);
        check("sub_ng", bus.ng, 1);
        check("sub_zr", bus.zr, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_out_stable", bus.out, 16'hFFFE);
            check("bp_ng_stable", bus.ng, 1);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        set_op(16'd7, 16'd0, 6'b001100, 1'b0);
        bus.in_valid = 1'b1;
        #1;
        check("bp_drain_accept_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("[TB] pass-x 7 -> 0x%0h", bus.out);
        check("bp_next_out", bus.out, 7);
        check("bp_next_valid", bus.out_valid, 1);
        @(negedge clk);

        // Back-to-back with out_ready held high
        for (int i = 0; i < 3; i++) begin
            set_op(16'h1234, 16'h0F0F, b2b_ctrl[i], 1'b0);
            bus.in_valid = 1'b1;
            #1;
            check("b2b_in_ready", bus.in_ready, 1);
            @(negedge clk);
            $display("[TB] b2b op %0d -> 0x%0h", i, bus.out);
            check("b2b_out", bus.out, b2b_exp[i]);
            check("b2b_zr", bus.zr, (b2b_exp[i] == '0));
            check("b2b_ng", bus.ng, b2b_exp[i][WIDTH-1]);
            check("b2b_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

`ifdef ALU_MUL_EN
        // 300 * 300, low 16 bits 0x5F90
        set_op(16'd300, 16'd300, 6'b000010, 1'b1);
        bus.in_valid = 1'b1;
        #1;
        check("mul_accept_ready", bus.in_ready, 1);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("mul_busy_in_ready", bus.in_ready, 0);
            check("mul_busy_out_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        $display("[TB] mul 300*300 -> 0x%0h", bus.out);
        check("mul_out", bus.out, 16'h5F90);
        check("mul_valid", bus.out_valid, 1);
        check("mul_zr", bus.zr, 0);
        check("mul_ng", bus.ng, 0);
        @(negedge clk);

        // Reset pulsed mid-multiply
        set_op(16'd300, 16'd300, 6'b000010, 1'b1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mulrst_out", bus.out, 0);
        check("mulrst_zr", bus.zr, 1);
        check("mulrst_valid", bus.out_valid, 0);
        check("mulrst_in_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < WIDTH + 3; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            check("mulrst_no_result", seen, 0);
            check("mulrst_out_after", bus.out, 0);
        end
`else
        // mul is ignored: plain x + y
        set_op(16'd300, 16'd300, 6'b000010, 1'b1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("[TB] mul-off 300,300 -> 0x%0h", bus.out);
        check("nomul_out", bus.out, 600);
        check("nomul_valid", bus.out_valid, 1);
        @(negedge clk);
`endif

        // Randomized traffic from a clean reset
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        model_valid = 1'b0;
        busy        = 0;
        txn_no      = 0;
        exp_q.delete();
        for (int i = 0; i < 400; i++) rnd_cycle(1'b1);
        for (int i = 0; i < 4 * WIDTH && (exp_q.size() != 0 || busy != 0 || model_valid); i++)
            rnd_cycle(1'b0);
        check("rnd_all_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
